// File: rtl/toggle_pkg.sv
// Shared types for the toggle request source: FSM state encoding and
// synchroniser depth used on the returning acknowledge level.
package toggle_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } tsrc_state_t;

    // Depth of the flop chain that brings ack_tgl into the clk domain.
    localparam int ACK_SYNC_STAGES = 2;

endpackage : toggle_pkg

// File: rtl/toggle_req_src_sync_dff.sv
// Two-flop level synchroniser for signals arriving from another clock
// domain. Output lags the input by two clk edges.
module sync_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_dff

// File: rtl/toggle_req_src.sv
// Source end of a two-phase toggle handshake. Each local request pulse
// becomes one toggle of req_tgl; the next toggle waits until the remote
// side echoes the current level back on ack_tgl. Requests arriving while a
// handshake is outstanding are held in a saturating pending counter.
module toggle_req_src #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    output logic             req_tgl,
    input  logic             ack_tgl,
    output logic             done_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    import toggle_pkg::*;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    tsrc_state_t      state_q, state_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] pend_q, pend_d;

    logic ack_s;
    logic launch;
    logic dec;
    logic acc;
    logic dropped;
    logic ack_match;

    sync_dff #(.WIDTH(1)) u_sync_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ack_tgl),
        .q_o   (ack_s)
    );

    // Next-state decode: launch/ack decisions and saturating counter update.
    always_comb begin
        // A launch with an empty counter consumes the incoming pulse directly;
        // otherwise the launch drains one queued request.
        launch    = (state_q == IDLE) && (pulse_in || (pend_q != '0));
        dec       = launch && (pend_q != '0);
        dropped   = pulse_in && (pend_q == PEND_MAX) && !dec;
        acc       = pulse_in && !dropped && !(launch && (pend_q == '0));
        // Acknowledge levels are only meaningful while a handshake is open.
        ack_match = (state_q == WAIT_ACK) && (ack_s == req_q);

        state_d = state_q;
        if (launch) begin
            state_d = WAIT_ACK;
        end else if (ack_match) begin
            state_d = IDLE;
        end

        pend_d = pend_q;
        if (acc && !dec) begin
            pend_d = pend_q + 1'b1;
        end else if (dec && !acc) begin
            pend_d = pend_q - 1'b1;
        end

        req_d  = launch ? ~req_q : req_q;
        done_d = ack_match;
        ovf_d  = dropped;
        busy_d = (state_d == WAIT_ACK) || (pend_d != '0);
    end

    // Single registered FSM: state, counter and every output flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign req_tgl    = req_q;
    assign done_pulse = done_q;
    assign busy       = busy_q;
    assign pending    = pend_q;
    assign overflow   = ovf_q;

endmodule : toggle_req_src

// File: tb/tb_toggle_req_src.sv
// Bench for toggle_req_src: a CNT_W=4 instance for the main scenarios and
// a CNT_W=2 instance for saturation. Each accepted request pushes the
// req_tgl level its completion must show; a negedge monitor pops on every
// done_pulse and compares.
module tb_toggle_req_src;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pulse4, req4, ack4, done4, busy4, ovf4;
    logic [3:0] pend4;
    logic       pulse2, req2, ack2, done2, busy2, ovf2;
    logic [1:0] pend2;

    logic       hold2, flip4;
    logic [2:0] dly4, dly2;

    int   total = 0;
    int   bad   = 0;
    int   dn4   = 0;
    int   dn2   = 0;
    int   tg4   = 0;
    int   nreq4 = 0;
    int   nreq2 = 0;
    logic prev4;
    logic exp_q4[$];
    logic exp_q2[$];

    toggle_req_src #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse4), .req_tgl(req4),
        .ack_tgl(ack4), .done_pulse(done4), .busy(busy4),
        .pending(pend4), .overflow(ovf4)
    );

    toggle_req_src #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse2), .req_tgl(req2),
        .ack_tgl(ack2), .done_pulse(done2), .busy(busy2),
        .pending(pend2), .overflow(ovf2)
    );

    // Remote side: echoes req_tgl back after three clk; dut2 echo can be frozen.
    always @(posedge clk) begin
        if (!rst_n) begin
            dly4 <= '0;
            dly2 <= '0;
        end else begin
            dly4 <= {dly4[1:0], req4};
            if (!hold2) dly2 <= {dly2[1:0], req2};
        end
    end
    assign ack4 = dly4[2] ^ flip4;
    assign ack2 = dly2[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every completion must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            dn4++;
            if (exp_q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done4_unexpected: got done_pulse with no request outstanding");
            end else begin
                chk("done4_level", {31'd0, req4}, {31'd0, exp_q4.pop_front()});
            end
        end
        if (done2 === 1'b1) begin
            dn2++;
            if (exp_q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done2_unexpected: got done_pulse with no request outstanding");
            end else begin
                chk("done2_level", {31'd0, req2}, {31'd0, exp_q2.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (req4 !== prev4) tg4++;
        prev4 = req4;
    endtask

    task automatic push4();
        nreq4++;
        exp_q4.push_back(nreq4[0]);
    endtask

    task automatic push2();
        nreq2++;
        exp_q2.push_back(nreq2[0]);
    endtask

    task automatic wait_idle(input bit use2, input string name);
        int n;
        n = 0;
        while (((use2 ? busy2 : busy4) !== 1'b0) && (n < 200)) begin
            tick();
            n++;
        end
        chk(name, (n < 200) ? 32'd1 : 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        pulse4 = 1'b0;
        pulse2 = 1'b0;
        hold2  = 1'b0;
        flip4  = 1'b0;
        prev4  = 1'b0;
        repeat (3) tick();
        chk("rst_req4",  req4,  0);
        chk("rst_done4", done4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_pend4", pend4, 0);
        chk("rst_ovf4",  ovf4,  0);
        chk("rst_req2",  req2,  0);
        chk("rst_pend2", pend2, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Single request: launch next cycle, completion six cycles later.
        dn4 = 0;
        pulse4 = 1'b1; push4(); tick(); pulse4 = 1'b0;
        chk("t1_req",  req4,  1);
        chk("t1_busy", busy4, 1);
        chk("t1_pend", pend4, 0);
        repeat (5) tick();
        chk("t1_ack_s",   dut4.ack_s, 1);
        chk("t1_no_done", done4,      0);
        tick();
        chk("t1_done",      done4, 1);
        chk("t1_busy_low",  busy4, 0);
        chk("t1_pend_end",  pend4, 0);
        tick();
        chk("t1_done_once", done4, 0);
        chk("t1_dn",        dn4,   1);

        // Burst of three back-to-back requests.
        dn4 = 0; tg4 = 0;
        for (int i = 0; i < 3; i++) begin
            pulse4 = 1'b1; push4(); tick();
        end
        pulse4 = 1'b0;
        chk("t2_pend_peak", pend4, 2);
        wait_idle(1'b0, "t2_idle");
        chk("t2_toggles", tg4,   3);
        chk("t2_dones",   dn4,   3);
        chk("t2_pend",    pend4, 0);

        // Saturation on the narrow instance with the echo frozen.
        dn2 = 0; hold2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse2 = 1'b1;
            if (i < 4) push2();
            tick();
            if (i == 3) chk("t3_no_ovf_yet", ovf2, 0);
        end
        pulse2 = 1'b0;
        chk("t3_ovf",  ovf2,  1);
        chk("t3_pend", pend2, 3);
        chk("t3_req",  req2,  1);
        chk("t3_busy", busy2, 1);
        tick();
        chk("t3_ovf_pulse", ovf2,  0);
        chk("t3_pend_hold", pend2, 3);
        hold2 = 1'b0;
        wait_idle(1'b1, "t3_idle");
        chk("t3_dones", dn2, 4);

        // Request arriving in the same cycle as the acknowledge match.
        dn4 = 0;
        pulse4 = 1'b1; push4(); tick(); pulse4 = 1'b0;
        chk("t4_launch", req4, 1);
        repeat (5) tick();
        pulse4 = 1'b1; push4(); tick(); pulse4 = 1'b0;
        chk("t4_done",   done4, 1);
        chk("t4_pend",   pend4, 1);
        chk("t4_req",    req4,  1);
        tick();
        chk("t4_relaunch",  req4,  0);
        chk("t4_pend_zero", pend4, 0);
        chk("t4_busy",      busy4, 1);
        wait_idle(1'b0, "t4_idle");
        chk("t4_dones", dn4, 2);

        // Reset in the middle of a handshake with two requests queued.
        for (int i = 0; i < 3; i++) begin
            pulse4 = 1'b1; push4(); tick();
        end
        pulse4 = 1'b0;
        chk("t5_pend_pre", pend4, 2);
        rst_n = 1'b0;
        exp_q4.delete(); nreq4 = 0;
        exp_q2.delete(); nreq2 = 0;
        dn4 = 0;
        tick();
        chk("t5_req",   req4,  0);
        chk("t5_done",  done4, 0);
        chk("t5_busy",  busy4, 0);
        chk("t5_pend",  pend4, 0);
        chk("t5_ovf",   ovf4,  0);
        chk("t5_state", dut4.state_q, 0);
        rst_n = 1'b1;
        tick();
        pulse4 = 1'b1; push4(); tick(); pulse4 = 1'b0;
        chk("t5_new_req", req4, 1);
        wait_idle(1'b0, "t5_idle");
        chk("t5_dones", dn4, 1);

        // Acknowledge wiggle while idle must be ignored.
        dn4 = 0; tg4 = 0;
        flip4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_done_a", done4, 0);
            chk("t6_busy_a", busy4, 0);
        end
        flip4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_done_b", done4, 0);
            chk("t6_busy_b", busy4, 0);
        end
        chk("t6_req",     req4, 1);
        chk("t6_toggles", tg4,  0);
        chk("t6_dones",   dn4,  0);

        chk("end_q4_empty", exp_q4.size(), 0);
        chk("end_q2_empty", exp_q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_toggle_req_src
